// File: rtl/alu_pipe_if.sv
// Handshake bundle between the operand front end, alu_pipe and the result consumer.
// The slave modport is the ALU's view; master is the producer/consumer side.
interface alu_pipe_if #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) ();

    logic                 i_valid;
    logic                 o_ready;
    logic [NB_DATA-1:0]   i_op_1;
    logic [NB_DATA-1:0]   i_op_2;
    logic [NB_OPCODE-1:0] i_opcode;
    logic                 i_use_acc;

    logic                 o_valid;
    logic                 i_ready;
    logic [NB_DATA-1:0]   o_result;
    logic                 o_carry;
    logic                 o_overflow;
    logic                 o_zero;
    logic                 o_negative;
    logic                 o_err;

    modport master (
        output i_valid, i_op_1, i_op_2, i_opcode, i_use_acc, i_ready,
        input  o_ready, o_valid, o_result, o_carry, o_overflow, o_zero, o_negative, o_err
    );

    modport slave (
        input  i_valid, i_op_1, i_op_2, i_opcode, i_use_acc, i_ready,
        output o_ready, o_valid, o_result, o_carry, o_overflow, o_zero, o_negative, o_err
    );

endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, registered flags and a
// result accumulator that chained operations can use as their first operand.
module alu_pipe #(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input logic       i_clk,
    input logic       i_rst,
    alu_pipe_if.slave bus
);

    localparam int MSB = NB_DATA - 1;

    localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
    localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
    localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
    localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
    localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
    localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
    localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
    localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);

    localparam logic [NB_DATA-1:0] SHIFT_LIMIT = NB_DATA'(NB_DATA);

    logic                 s1_valid;
    logic [NB_DATA-1:0]   s1_op_1;
    logic [NB_DATA-1:0]   s1_op_2;
    logic [NB_OPCODE-1:0] s1_opcode;
    logic                 s1_use_acc;

    logic                 out_valid;
    logic [NB_DATA-1:0]   out_result;
    logic                 out_carry;
    logic                 out_overflow;
    logic                 out_zero;
    logic                 out_negative;
    logic                 out_err;
    logic [NB_DATA-1:0]   acc;

    logic                 s1_en;
    logic                 s2_en;

    logic [NB_DATA-1:0]   op_a;
    logic [NB_DATA-1:0]   op_b;
    logic [NB_DATA:0]     sum;
    logic [NB_DATA-1:0]   diff;
    logic signed [NB_DATA-1:0] sra_shifted;
    logic [NB_DATA-1:0]   alu_result;
    logic                 alu_carry;
    logic                 alu_overflow;
    logic                 alu_err;

    // S2 frees up whenever its result leaves or it is empty; S1 rides on S2.
    assign s2_en       = !out_valid || bus.i_ready;
    assign s1_en       = !s1_valid || s2_en;
    assign bus.o_ready = s1_en;

    assign op_a        = s1_use_acc ? acc : s1_op_1;
    assign op_b        = s1_op_2;
    assign sum         = {1'b0, op_a} + {1'b0, op_b};
    assign diff        = op_a - op_b;
    assign sra_shifted = $signed(op_a) >>> op_b;

    always_comb begin
        alu_result   = '0;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        alu_err      = 1'b0;
        case (s1_opcode)
            OP_ADD: begin
                alu_result   = sum[NB_DATA-1:0];
                alu_carry    = sum[NB_DATA];
                alu_overflow = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
            end
            OP_SUB: begin
                alu_result   = diff;
                alu_carry    = op_a < op_b;
                alu_overflow = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
            end
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_NOR:  alu_result = ~(op_a | op_b);
            // Oversized shift amounts are clamped explicitly rather than relying on operator semantics.
            OP_SRL:  alu_result = (op_b >= SHIFT_LIMIT) ? '0 : (op_a >> op_b);
            OP_SRA:  alu_result = (op_b >= SHIFT_LIMIT) ? {NB_DATA{op_a[MSB]}} : $unsigned(sra_shifted);
            default: alu_err    = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_op_1    <= '0;
            s1_op_2    <= '0;
            s1_opcode  <= '0;
            s1_use_acc <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= bus.i_valid;
            if (bus.i_valid) begin
                s1_op_1    <= bus.i_op_1;
                s1_op_2    <= bus.i_op_2;
                s1_opcode  <= bus.i_opcode;
                s1_use_acc <= bus.i_use_acc;
            end
        end
    end

    // The accumulator loads together with S2, so the next op always sees this result.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
            out_negative <= 1'b0;
            out_err      <= 1'b0;
            acc          <= '0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result   <= alu_result;
                out_carry    <= alu_carry;
                out_overflow <= alu_overflow;
                out_zero     <= (alu_result == '0);
                out_negative <= alu_result[MSB];
                out_err      <= alu_err;
                acc          <= alu_result;
            end
        end
    end

    assign bus.o_valid    = out_valid;
    assign bus.o_result   = out_result;
    assign bus.o_carry    = out_carry;
    assign bus.o_overflow = out_overflow;
    assign bus.o_zero     = out_zero;
    assign bus.o_negative = out_negative;
    assign bus.o_err      = out_err;

endmodule
